// File: rtl/sdram_port_ctrl_if.sv
// Oric RAM toggle-handshake port: request fields from the CPU side, ack toggle and read data back.
// A request is pending while port_req != port_ack; master drives requests, slave answers them.
interface sdram_port_ctrl_if;
  logic        port_req;
  logic        port_ack;
  logic [15:0] port_a;
  logic [1:0]  port_ds;
  logic        port_we;
  logic [15:0] port_d;
  logic [15:0] port_q;
  logic [7:0]  port_qb;

  modport master (
    output port_req, port_a, port_ds, port_we, port_d,
    input  port_ack, port_q, port_qb
  );

  modport slave (
    input  port_req, port_a, port_ds, port_we, port_d,
    output port_ack, port_q, port_qb
  );
endinterface

// File: rtl/sdram_port_ctrl.sv
// SDRAM responder: power-up init, periodic auto-refresh, single-word bank-0 accesses with auto-precharge.
// ACT one cycle after acceptance, write ack at c2, read data/ack at c4; requests wait only on the toggle handshake.
module sdram_port_ctrl #(
  parameter int INIT_WAIT      = 7200,
  parameter int REFRESH_CYCLES = 560
) (
  input  logic               clk,
  input  logic               init_n,
  sdram_port_ctrl_if.slave   host,
  output logic [12:0]        SDRAM_A,
  output logic [1:0]         SDRAM_BA,
  inout  wire  [15:0]        SDRAM_DQ,
  output logic               SDRAM_DQML,
  output logic               SDRAM_DQMH,
  output logic               SDRAM_nCS,
  output logic               SDRAM_nRAS,
  output logic               SDRAM_nCAS,
  output logic               SDRAM_nWE
);

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam int CW = ($clog2(INIT_WAIT + 1) < 4) ? 4 : $clog2(INIT_WAIT + 1);
  localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2,
    S_INIT_MRS, S_IDLE, S_ACCESS, S_REFRESH
  } state_t;

  typedef struct packed {
    logic [7:0]  col;
    logic        a0;
    logic [1:0]  ds;
    logic        we;
    logic [15:0] d;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          lat_q;
  logic [3:0]    cmd_q, cmd_d;
  logic [12:0]   a_q, a_d;
  logic [1:0]    dqm_q, dqm_d;
  logic          dq_oe_q, dq_oe_d;
  logic [15:0]   dq_out_q;
  logic          ack_q;
  logic [15:0]   q_q;
  logic [7:0]    qb_q;
  logic          ref_run_q, ref_pend_q;
  logic [RW-1:0] rcnt_q;
  logic          accept, ref_issue, pending, ref_tick, wr_done, rd_sample;

  assign pending   = host.port_req ^ ack_q;
  assign ref_tick  = (ref_run_q || state_q == S_IDLE) && (rcnt_q == RW'(REFRESH_CYCLES - 1));
  assign wr_done   = (state_q == S_ACCESS) &&  lat_q.we && (cnt_q == CW'(2));
  assign rd_sample = (state_q == S_ACCESS) && !lat_q.we && (cnt_q == CW'(4));

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= S_INIT_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds the index of the current cycle within each state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S_INIT_WAIT: if (cnt_q == CW'(INIT_WAIT)) begin state_d = S_INIT_PRE;  cnt_d = '0; end
      S_INIT_PRE:  if (cnt_q == CW'(2))         begin state_d = S_INIT_REF1; cnt_d = '0; end
      S_INIT_REF1: if (cnt_q == CW'(8))         begin state_d = S_INIT_REF2; cnt_d = '0; end
      S_INIT_REF2: if (cnt_q == CW'(8))         begin state_d = S_INIT_MRS;  cnt_d = '0; end
      S_INIT_MRS:  if (cnt_q == CW'(2))         begin state_d = S_IDLE;      cnt_d = '0; end
      S_IDLE: begin
        cnt_d = '0;
        if (ref_pend_q)   state_d = S_REFRESH;
        else if (pending) state_d = S_ACCESS;
      end
      S_ACCESS:    if (cnt_q == CW'(7))         begin state_d = S_IDLE;      cnt_d = '0; end
      S_REFRESH:   if (cnt_q == CW'(7))         begin state_d = S_IDLE;      cnt_d = '0; end
      default:     begin state_d = S_INIT_WAIT; cnt_d = '0; end
    endcase
  end

  // Values for the pins in the next cycle; the command bus is always registered
  always_comb begin
    cmd_d     = CMD_NOP;
    a_d       = a_q;
    dqm_d     = 2'b11;
    dq_oe_d   = 1'b0;
    accept    = 1'b0;
    ref_issue = 1'b0;
    case (state_q)
      S_INIT_WAIT: if (cnt_q == CW'(INIT_WAIT)) begin cmd_d = CMD_PRE; a_d = 13'h0400; end
      S_INIT_PRE:  if (cnt_q == CW'(2)) cmd_d = CMD_REF;
      S_INIT_REF1: if (cnt_q == CW'(8)) cmd_d = CMD_REF;
      S_INIT_REF2: if (cnt_q == CW'(8)) begin cmd_d = CMD_MRS; a_d = 13'h0020; end
      S_IDLE: begin
        if (ref_pend_q) begin
          cmd_d     = CMD_REF;
          ref_issue = 1'b1;
        end else if (pending) begin
          cmd_d  = CMD_ACT;
          a_d    = {6'b0, host.port_a[15:9]};
          accept = 1'b1;
        end
      end
      S_ACCESS: begin
        if (cnt_q == CW'(1)) begin
          cmd_d   = lat_q.we ? CMD_WRITE : CMD_READ;
          a_d     = {2'b00, 1'b1, 2'b00, lat_q.col};
          dqm_d   = lat_q.we ? ~lat_q.ds : 2'b00;
          dq_oe_d = lat_q.we;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cmd_q      <= CMD_DESEL;
      a_q        <= '0;
      dqm_q      <= 2'b11;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
      lat_q      <= '0;
      ack_q      <= 1'b0;
      q_q        <= '0;
      qb_q       <= '0;
      ref_run_q  <= 1'b0;
      ref_pend_q <= 1'b0;
      rcnt_q     <= '0;
    end else begin
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      dqm_q   <= dqm_d;
      dq_oe_q <= dq_oe_d;
      if (dq_oe_d) dq_out_q <= lat_q.d;
      if (accept)
        lat_q <= '{col: host.port_a[8:1], a0: host.port_a[0], ds: host.port_ds,
                   we: host.port_we, d: host.port_d};
      if (wr_done) ack_q <= ~ack_q;
      if (rd_sample) begin
        q_q   <= SDRAM_DQ;
        qb_q  <= lat_q.a0 ? SDRAM_DQ[15:8] : SDRAM_DQ[7:0];
        ack_q <= ~ack_q;
      end
      // Refresh timebase free-runs from the first IDLE, independent of accesses
      if (state_q == S_IDLE) ref_run_q <= 1'b1;
      if (ref_run_q || state_q == S_IDLE)
        rcnt_q <= ref_tick ? '0 : rcnt_q + 1'b1;
      if (ref_issue) ref_pend_q <= 1'b0;
      if (ref_tick)  ref_pend_q <= 1'b1;
    end
  end

  assign {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} = cmd_q;
  assign {SDRAM_DQMH, SDRAM_DQML} = dqm_q;
  assign SDRAM_A  = a_q;
  assign SDRAM_BA = 2'b00;
  assign SDRAM_DQ = dq_oe_q ? dq_out_q : 16'hzzzz;

  assign host.port_ack = ack_q;
  assign host.port_q   = q_q;
  assign host.port_qb  = qb_q;

endmodule

// File: tb/tb_sdram_port_ctrl.sv
// Directed bench for sdram_port_ctrl with a behavioural bank-0 SDRAM (CL 2) on the pins.
// Cycle numbers count pin cycles from the first clock edge after init_n release.
module tb_sdram_port_ctrl;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;

  logic clk = 1'b0;
  logic init_n = 1'b0;
  always #5 clk = ~clk;

  sdram_port_ctrl_if bus ();

  wire [12:0] sd_a;
  wire [1:0]  sd_ba;
  wire [15:0] sd_dq;
  wire        dqml, dqmh, ncs, nras, ncas, nwe;
  logic        tb_dq_en = 1'b0;
  logic [15:0] tb_dq_val = 16'h0;
  assign sd_dq = tb_dq_en ? tb_dq_val : 16'hzzzz;

  sdram_port_ctrl #(.INIT_WAIT(20), .REFRESH_CYCLES(40)) dut (
    .clk        (clk),
    .init_n     (init_n),
    .host       (bus),
    .SDRAM_A    (sd_a),
    .SDRAM_BA   (sd_ba),
    .SDRAM_DQ   (sd_dq),
    .SDRAM_DQML (dqml),
    .SDRAM_DQMH (dqmh),
    .SDRAM_nCS  (ncs),
    .SDRAM_nRAS (nras),
    .SDRAM_nCAS (ncas),
    .SDRAM_nWE  (nwe)
  );

  wire [3:0] cmd = {ncs, nras, ncas, nwe};

  int cyc = -1;
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk or negedge init_n)
    if (!init_n) cyc <= -1;
    else         cyc <= cyc + 1;

  // SDRAM model plus ack/ACT event counters, all sampled mid-cycle
  logic [15:0] mem [0:32767];
  logic        mem_ready = 1'b0;
  logic [6:0]  act_row = 7'h0;
  logic [15:0] rd_word = 16'h0;
  int          rd_at = -100;
  logic        ack_prev = 1'b0;
  int          ack_tgl = 0;
  int          act_cnt = 0;

  always @(negedge clk) begin
    ack_prev <= bus.port_ack;
    if (bus.port_ack != ack_prev) ack_tgl <= ack_tgl + 1;
    if (!mem_ready) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'h0;
      mem[15'h1234] <= 16'hD1F7;
      mem_ready <= 1'b1;
    end
    tb_dq_en  <= init_n && (cyc == rd_at);
    tb_dq_val <= rd_word;
    if (!init_n) rd_at <= -100;
    else begin
      case (cmd)
        ACT: begin act_row <= sd_a[6:0]; act_cnt <= act_cnt + 1; end
        WR: begin
          if (!dqmh) mem[{act_row, sd_a[7:0]}][15:8] <= sd_dq[15:8];
          if (!dqml) mem[{act_row, sd_a[7:0]}][7:0]  <= sd_dq[7:0];
        end
        RD: begin rd_word <= mem[{act_row, sd_a[7:0]}]; rd_at <= cyc + 2; end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of pin cycle c
  task automatic to_cyc(input int c);
    int guard = 0;
    while (cyc != c && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) chk("cycle_wait", 32'(cyc), 32'(c));
  endtask

  task automatic chk_reset();
    chk("rst_cmd", 32'(cmd), 32'hF);
    chk("rst_a", 32'(sd_a), 32'h0);
    chk("rst_ba", 32'(sd_ba), 32'h0);
    chk("rst_dqm", 32'({dqmh, dqml}), 32'h3);
    chk("rst_ack", 32'(bus.port_ack), 32'h0);
    chk("rst_q", 32'(bus.port_q), 32'h0);
    chk("rst_qb", 32'(bus.port_qb), 32'h0);
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk);
    init_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_cmd;
    int t0, t1, a0, last_ref, nref, gap;

    bus.port_req = 1'b0;
    bus.port_a   = 16'h0;
    bus.port_ds  = 2'b11;
    bus.port_we  = 1'b0;
    bus.port_d   = 16'h0;

    @(negedge clk);
    init_n = 1'b0;
    #1 chk_reset();
    release_reset();

    // Power-up: 20 NOPs, PRE, REF at 23 and 32, MRS at 41, first IDLE at 44
    for (int c = 0; c <= 44; c++) begin
      to_cyc(c);
      exp_cmd = (c == 20) ? PRE : (c == 23 || c == 32) ? REF : (c == 41) ? MRS : NOP;
      chk("init_cmd", 32'(cmd), 32'(exp_cmd));
      if (c == 20) chk("pre_a", 32'(sd_a), 32'h0400);
      if (c == 41) chk("mrs_a", 32'(sd_a), 32'h0020);
    end

    // Write 0xAB00 high byte at 0x1235
    bus.port_a = 16'h1235; bus.port_ds = 2'b10; bus.port_d = 16'hAB00; bus.port_we = 1'b1;
    bus.port_req = 1'b1;
    to_cyc(45);
    chk("wr_act", 32'(cmd), 32'(ACT));
    chk("wr_row", 32'(sd_a), 32'h0009);
    bus.port_a = 16'hFFFF; bus.port_ds = 2'b11; bus.port_d = 16'h5555; bus.port_we = 1'b0;
    to_cyc(46);
    chk("wr_c1", 32'(cmd), 32'(NOP));
    to_cyc(47);
    chk("wr_cmd", 32'(cmd), 32'(WR));
    chk("wr_col", 32'(sd_a), 32'h041A);
    chk("wr_dqm", 32'({dqmh, dqml}), 32'h1);
    chk("wr_dq", 32'(sd_dq), 32'hAB00);
    chk("wr_ack_pre", 32'(bus.port_ack), 32'h0);
    to_cyc(48);
    chk("wr_ack", 32'(bus.port_ack), 32'h1);
    chk("wr_dqm_off", 32'({dqmh, dqml}), 32'h3);

    // Read back the same address
    to_cyc(53);
    bus.port_a = 16'h1235; bus.port_ds = 2'b11; bus.port_we = 1'b0;
    bus.port_req = 1'b0;
    to_cyc(54);
    chk("rd1_act", 32'(cmd), 32'(ACT));
    chk("rd1_row", 32'(sd_a), 32'h0009);
    to_cyc(56);
    chk("rd1_cmd", 32'(cmd), 32'(RD));
    chk("rd1_col", 32'(sd_a), 32'h041A);
    chk("rd1_dqm", 32'({dqmh, dqml}), 32'h0);
    to_cyc(58);
    chk("rd1_ack_pre", 32'(bus.port_ack), 32'h1);
    to_cyc(59);
    chk("rd1_ack", 32'(bus.port_ack), 32'h0);
    chk("rd1_q", 32'(bus.port_q), 32'hAB00);
    chk("rd1_qb", 32'(bus.port_qb), 32'hAB);

    // Back-to-back read of 0x2468 (word 0x1234), issued right after the ack
    bus.port_a = 16'h2468;
    bus.port_req = 1'b1;
    to_cyc(62);
    chk("b2b_c8", 32'(cmd), 32'(NOP));
    to_cyc(63);
    chk("b2b_act", 32'(cmd), 32'(ACT));
    chk("b2b_row", 32'(sd_a), 32'h0012);
    to_cyc(65);
    chk("b2b_cmd", 32'(cmd), 32'(RD));
    chk("b2b_col", 32'(sd_a), 32'h0434);
    to_cyc(68);
    chk("b2b_ack", 32'(bus.port_ack), 32'h1);
    chk("b2b_q", 32'(bus.port_q), 32'hD1F7);
    chk("b2b_qb", 32'(bus.port_qb), 32'hF7);

    // Refresh pending and a new request both appear after the edge ending cycle 83
    to_cyc(83);
    @(posedge clk);
    #1;
    bus.port_a = 16'h1235; bus.port_we = 1'b0;
    bus.port_req = 1'b0;
    to_cyc(84);
    t0 = ack_tgl;
    chk("col_c84", 32'(cmd), 32'(NOP));
    to_cyc(85);
    chk("col_ref", 32'(cmd), 32'(REF));
    for (int c = 86; c <= 93; c++) begin
      to_cyc(c);
      chk("col_gap", 32'(cmd), 32'(NOP));
    end
    to_cyc(94);
    chk("col_act", 32'(cmd), 32'(ACT));
    to_cyc(96);
    chk("col_rd", 32'(cmd), 32'(RD));
    to_cyc(99);
    chk("col_q", 32'(bus.port_q), 32'hAB00);
    to_cyc(101);
    chk("col_acks", 32'(ack_tgl - t0), 32'h1);

    // Read of 0x2468 aborted by reset in c1
    to_cyc(102);
    bus.port_a = 16'h2468;
    bus.port_req = 1'b1;
    to_cyc(103);
    chk("abt_act", 32'(cmd), 32'(ACT));
    @(posedge clk);
    #2 init_n = 1'b0;
    #1 chk_reset();
    t1 = ack_tgl;
    release_reset();
    a0 = act_cnt;

    to_cyc(44);
    chk("re_c44", 32'(cmd), 32'(NOP));
    chk("re_noack", 32'(bus.port_ack), 32'h0);
    to_cyc(45);
    chk("re_act", 32'(cmd), 32'(ACT));
    chk("re_row", 32'(sd_a), 32'h0012);
    to_cyc(47);
    chk("re_rd", 32'(cmd), 32'(RD));
    chk("re_col", 32'(sd_a), 32'h0434);
    to_cyc(49);
    chk("re_ack_pre", 32'(bus.port_ack), 32'h0);
    to_cyc(50);
    chk("re_ack", 32'(bus.port_ack), 32'h1);
    chk("re_q", 32'(bus.port_q), 32'hD1F7);
    chk("re_qb", 32'(bus.port_qb), 32'hF7);

    // No request pending: only REFs, first at 85, then every 40 cycles
    last_ref = -1;
    nref = 0;
    for (int c = 51; c <= 1060; c++) begin
      to_cyc(c);
      if (cmd != NOP) begin
        chk("idle_cmd", 32'(cmd), 32'(REF));
        if (cmd == REF) begin
          if (last_ref < 0) chk("first_ref", 32'(c), 32'd85);
          else begin
            gap = c - last_ref;
            chk("ref_gap_ok", 32'(gap >= 32 && gap <= 48), 32'h1);
          end
          last_ref = c;
          nref++;
        end
      end
    end
    chk("ref_count", 32'(nref), 32'd25);
    chk("act_once", 32'(act_cnt - a0), 32'h1);
    chk("ack_once", 32'(ack_tgl - t1), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
